// File: rtl/sort_frequent_core_if.sv
// Data bus of the Huffman frequency sorter: packed per-symbol counts in and
// the sorted {symbol, count} list out. There is no handshake on this bus.
interface sort_frequent_core_if #(
    parameter int NUM_SYM = 4,
    parameter int FREQ_W  = 4
);
    logic [NUM_SYM*FREQ_W-1:0]   FREQUENT_IN;
    logic [NUM_SYM*2*FREQ_W-1:0] FREQUENT_OUT;

    // Valid/ready semantics: none. FREQUENT_IN is sampled once per round in
    // LOAD; FREQUENT_OUT changes only in DONE and is held for a full round.
    modport master (output FREQUENT_IN, input FREQUENT_OUT);
    modport slave  (input FREQUENT_IN, output FREQUENT_OUT);
endinterface

// File: rtl/sort_frequent_core.sv
// Frequency sorter: odd-even transposition network, one phase per clock,
// re-sorting continuously. Define SORT_FREQUENT_DESCEND_EN for descending order.
module sort_frequent_core #(
    parameter int NUM_SYM = 4,
    parameter int FREQ_W  = 4
) (
    input  logic                       CLK,
    input  logic                       nRST,
    sort_frequent_core_if.slave        bus,
    output logic [1:0]                 state_dbg,
    output logic [$clog2(NUM_SYM)-1:0] ph_dbg
);
    localparam int PH_W  = $clog2(NUM_SYM);
    localparam int OUT_W = NUM_SYM * 2 * FREQ_W;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(NUM_SYM - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [FREQ_W-1:0] idx_q [NUM_SYM];
    logic [FREQ_W-1:0] cnt_q [NUM_SYM];
    logic [FREQ_W-1:0] idx_d [NUM_SYM];
    logic [FREQ_W-1:0] cnt_d [NUM_SYM];
    logic [OUT_W-1:0]  out_pack;
    logic              publish;

    // Strict comparison keeps equal counts in their current order (stable sort).
    function automatic logic need_swap(input logic [FREQ_W-1:0] lo_cnt,
                                       input logic [FREQ_W-1:0] hi_cnt);
`ifdef SORT_FREQUENT_DESCEND_EN
        return lo_cnt < hi_cnt;
`else
        return lo_cnt > hi_cnt;
`endif
    endfunction

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        publish = 1'b0;
        for (int k = 0; k < NUM_SYM; k++) begin
            idx_d[k] = idx_q[k];
            cnt_d[k] = cnt_q[k];
        end

        case (state_q)
            LOAD: begin
                for (int k = 0; k < NUM_SYM; k++) begin
                    idx_d[k] = FREQ_W'(k);
                    cnt_d[k] = bus.FREQUENT_IN[FREQ_W*k +: FREQ_W];
                end
                ph_d    = '0;
                state_d = SORT;
            end
            SORT: begin
                // Even phases pair (0,1),(2,3)...; odd phases pair (1,2),(3,4)...
                for (int p = 0; p < NUM_SYM - 1; p++) begin
                    if (1'(p) == ph_q[0] && need_swap(cnt_q[p], cnt_q[p+1])) begin
                        idx_d[p]   = idx_q[p+1];
                        cnt_d[p]   = cnt_q[p+1];
                        idx_d[p+1] = idx_q[p];
                        cnt_d[p+1] = cnt_q[p];
                    end
                end
                if (ph_q == PH_LAST) begin
                    ph_d    = '0;
                    state_d = DONE;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            DONE: begin
                publish = 1'b1;
                state_d = LOAD;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_comb begin
        out_pack = '0;
        for (int j = 0; j < NUM_SYM; j++) begin
            out_pack[2*FREQ_W*j +: 2*FREQ_W] = {idx_q[j], cnt_q[j]};
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q          <= LOAD;
            ph_q             <= '0;
            bus.FREQUENT_OUT <= '0;
            for (int k = 0; k < NUM_SYM; k++) begin
                idx_q[k] <= '0;
                cnt_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            for (int k = 0; k < NUM_SYM; k++) begin
                idx_q[k] <= idx_d[k];
                cnt_q[k] <= cnt_d[k];
            end
            if (publish) begin
                bus.FREQUENT_OUT <= out_pack;
            end
        end
    end

    assign state_dbg = state_q;
    assign ph_dbg    = ph_q;
endmodule

// File: tb/tb_sort_frequent_core.sv
// Bench for sort_frequent_core: directed and random rounds against a
// stable selection-sort reference model.
module tb_sort_frequent_core;
  localparam int NUM_SYM = 4;
  localparam int FREQ_W  = 4;
  localparam int IN_W    = NUM_SYM * FREQ_W;
  localparam int OUT_W   = 2 * IN_W;
  localparam logic [1:0] ST_LOAD = 2'd0;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic [1:0] state_dbg;
  logic [1:0] ph_dbg;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [OUT_W-1:0] exp_q[$];

  sort_frequent_core_if #(.NUM_SYM(NUM_SYM), .FREQ_W(FREQ_W)) bus ();

  sort_frequent_core #(.NUM_SYM(NUM_SYM), .FREQ_W(FREQ_W)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .bus       (bus),
    .state_dbg (state_dbg),
    .ph_dbg    (ph_dbg)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // Reference: repeatedly pick the smallest (or largest) remaining count,
  // earliest symbol winning ties, which is exactly a stable sort.
  function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] v);
    logic [OUT_W-1:0] r;
    bit used [NUM_SYM];
    int cnt [NUM_SYM];
    int best;
    r = '0;
    for (int k = 0; k < NUM_SYM; k++) begin
      used[k] = 1'b0;
      cnt[k] = int'(v[FREQ_W*k +: FREQ_W]);
    end
    for (int j = 0; j < NUM_SYM; j++) begin
      best = -1;
      for (int k = 0; k < NUM_SYM; k++) begin
        if (!used[k]) begin
`ifdef SORT_FREQUENT_DESCEND_EN
          if (best < 0 || cnt[k] > cnt[best]) best = k;
`else
          if (best < 0 || cnt[k] < cnt[best]) best = k;
`endif
        end
      end
      used[best] = 1'b1;
      r[2*FREQ_W*j +: 2*FREQ_W] = {FREQ_W'(best), FREQ_W'(cnt[best])};
    end
    return r;
  endfunction

  // driver tasks
  task automatic wait_edges(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // After this returns, the next rising edge is edge 1 (LOAD).
  task automatic apply_reset();
    @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  function automatic logic [IN_W-1:0] rand_in();
    logic [IN_W-1:0] v;
    for (int k = 0; k < NUM_SYM; k++) begin
      if ($urandom_range(0, 1) == 1)
        v[FREQ_W*k +: FREQ_W] = FREQ_W'($urandom_range(0, 2));
      else
        v[FREQ_W*k +: FREQ_W] = FREQ_W'($urandom_range(0, 15));
    end
    return v;
  endfunction

  task automatic test_reset();
    bus.FREQUENT_IN = 16'h3121;
    nRST = 1'b0;
    wait_edges(2);
    vec_cnt++;
    if (bus.FREQUENT_OUT !== '0) begin
      err_cnt++;
      $display("FAIL reset_out: got %h expected %h", bus.FREQUENT_OUT, {OUT_W{1'b0}});
    end
    vec_cnt++;
    if (state_dbg !== ST_LOAD) begin
      err_cnt++;
      $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_LOAD);
    end
    vec_cnt++;
    if (ph_dbg !== 2'd0) begin
      err_cnt++;
      $display("FAIL reset_ph: got %0d expected 0", ph_dbg);
    end
  endtask

  task automatic test_directed();
    logic [IN_W-1:0] tbl [5];
    logic [OUT_W-1:0] exp;
    tbl[0] = 16'h3121; tbl[1] = 16'h5555; tbl[2] = 16'h1234;
    tbl[3] = 16'h0000; tbl[4] = 16'h0F0F;
    for (int i = 0; i < 5; i++) begin
      bus.FREQUENT_IN = tbl[i];
      exp = model(tbl[i]);
      apply_reset();
      wait_edges(5);
      vec_cnt++;
      if (bus.FREQUENT_OUT !== '0) begin
        err_cnt++;
        $display("FAIL early_out in=%h: got %h expected %h", tbl[i], bus.FREQUENT_OUT, {OUT_W{1'b0}});
      end
      wait_edges(1);
      vec_cnt++;
      if (bus.FREQUENT_OUT !== exp) begin
        err_cnt++;
        $display("FAIL directed in=%h: got %h expected %h", tbl[i], bus.FREQUENT_OUT, exp);
      end
    end
  endtask

  task automatic test_hold();
    logic [OUT_W-1:0] exp;
    bus.FREQUENT_IN = 16'h3121;
    exp = model(16'h3121);
    apply_reset();
    wait_edges(6);
    for (int e = 7; e <= 12; e++) begin
      wait_edges(1);
      vec_cnt++;
      if (bus.FREQUENT_OUT !== exp) begin
        err_cnt++;
        $display("FAIL hold edge%0d: got %h expected %h", e, bus.FREQUENT_OUT, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    bus.FREQUENT_IN = 16'h3121;
    apply_reset();
    wait_edges(1);
    bus.FREQUENT_IN = 16'h1234;
    wait_edges(5);
    vec_cnt++;
    if (bus.FREQUENT_OUT !== model(16'h3121)) begin
      err_cnt++;
      $display("FAIL midchange_first: got %h expected %h", bus.FREQUENT_OUT, model(16'h3121));
    end
    wait_edges(6);
    vec_cnt++;
    if (bus.FREQUENT_OUT !== model(16'h1234)) begin
      err_cnt++;
      $display("FAIL midchange_second: got %h expected %h", bus.FREQUENT_OUT, model(16'h1234));
    end
  endtask

  task automatic test_mid_reset();
    bus.FREQUENT_IN = 16'h3121;
    apply_reset();
    wait_edges(9);
    nRST = 1'b0;
    #1;
    vec_cnt++;
    if (bus.FREQUENT_OUT !== '0) begin
      err_cnt++;
      $display("FAIL midreset_out: got %h expected %h", bus.FREQUENT_OUT, {OUT_W{1'b0}});
    end
    vec_cnt++;
    if (state_dbg !== ST_LOAD) begin
      err_cnt++;
      $display("FAIL midreset_state: got %0d expected %0d", state_dbg, ST_LOAD);
    end
    @(negedge CLK);
    nRST = 1'b1;
    bus.FREQUENT_IN = 16'h0000;
    wait_edges(5);
    vec_cnt++;
    if (bus.FREQUENT_OUT !== '0) begin
      err_cnt++;
      $display("FAIL midreset_early: got %h expected %h", bus.FREQUENT_OUT, {OUT_W{1'b0}});
    end
    wait_edges(1);
    vec_cnt++;
    if (bus.FREQUENT_OUT !== model(16'h0000)) begin
      err_cnt++;
      $display("FAIL midreset_result: got %h expected %h", bus.FREQUENT_OUT, model(16'h0000));
    end
  endtask

  task automatic test_random();
    logic [IN_W-1:0] v;
    logic [OUT_W-1:0] exp;
    v = rand_in();
    bus.FREQUENT_IN = v;
    exp_q.push_back(model(v));
    apply_reset();
    wait_edges(6);
    for (int r = 0; r < 30; r++) begin
      exp = exp_q.pop_front();
      vec_cnt++;
      if (bus.FREQUENT_OUT !== exp) begin
        err_cnt++;
        $display("FAIL random round%0d: got %h expected %h", r, bus.FREQUENT_OUT, exp);
      end
      vec_cnt++;
      if (state_dbg !== ST_LOAD) begin
        err_cnt++;
        $display("FAIL random_state round%0d: got %0d expected %0d", r, state_dbg, ST_LOAD);
      end
      v = rand_in();
      bus.FREQUENT_IN = v;
      exp_q.push_back(model(v));
      wait_edges(1);
      bus.FREQUENT_IN = rand_in();
      wait_edges(5);
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
